// File: rtl/stream_upsize_flush_if.sv
// -----------------------------------------------------------------------------
// stream_upsize_flush_if
//   Bundles the narrow input stream, the flush request and the wide output
//   stream of stream_upsize_flush.
//   slave  : view taken by the packer (consumes s_*, produces m_*).
//   master : view taken by the surrounding logic / testbench.
//   Signals:
//     s_data_i  [T_DATA_WIDTH]   input beat
//     s_last_i                   last beat of packet
//     s_valid_i / s_ready_o      input handshake (s_ready_o is registered)
//     flush_i                    pulse: close the current partial word
//     m_data_o  [T_DATA_RATIO]   output lanes (unpacked), lane 0 = first beat
//     m_keep_o  [T_DATA_RATIO]   lane valid mask
//     m_last_o                   word carries the packet's last beat
//     m_valid_o / m_ready_i      output handshake
// -----------------------------------------------------------------------------
interface stream_upsize_flush_if #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2
);
    logic [T_DATA_WIDTH-1:0] s_data_i;
    logic                    s_last_i;
    logic                    s_valid_i;
    logic                    s_ready_o;
    logic                    flush_i;
    logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] m_keep_o;
    logic                    m_last_o;
    logic                    m_valid_o;
    logic                    m_ready_i;

    modport slave (
        input  s_data_i, s_last_i, s_valid_i, flush_i, m_ready_i,
        output s_ready_o, m_data_o, m_keep_o, m_last_o, m_valid_o
    );

    modport master (
        output s_data_i, s_last_i, s_valid_i, flush_i, m_ready_i,
        input  s_ready_o, m_data_o, m_keep_o, m_last_o, m_valid_o
    );
endinterface

// File: rtl/stream_upsize_flush.sv
// -----------------------------------------------------------------------------
// stream_upsize_flush
//   Packs a narrow valid/ready/last stream into words of T_DATA_RATIO lanes
//   with a per-lane keep mask. A word closes when its last lane fills, when a
//   packet-end beat is accepted (only case with m_last=1), on a flush request,
//   or after IDLE_TIMEOUT idle cycles (0 disables). Closed words go into a
//   2-entry FIFO whose head drives the output, so one beat per clock is
//   sustained in and one word per clock out.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous reset, active low
//     bus    stream_upsize_flush_if.slave (see interface header)
// -----------------------------------------------------------------------------
module stream_upsize_flush #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2,
    parameter int IDLE_TIMEOUT = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    stream_upsize_flush_if.slave       bus
);
    localparam int IDXW = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
    localparam int TW   = $clog2(IDLE_TIMEOUT + 2);
    // Counter value seen on the final idle cycle before an auto-close.
    localparam int TMAX = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;

    typedef struct packed {
        logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] data;
        logic [T_DATA_RATIO-1:0]                   keep;
        logic                                      last;
    } word_t;

    // Partial word under assembly
    logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] r_lane;
    logic [T_DATA_RATIO-1:0]                   r_keep;
    logic [IDXW-1:0]                           r_idx;
    logic [TW-1:0]                             r_tcnt;
    logic                                      r_flush_pend;

    // Output FIFO
    word_t       r_buf [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic        r_s_ready;

    logic        w_hs;
    logic        w_pop;
    logic        w_space;
    logic        w_part;
    logic        w_beat_close;
    logic        w_flush_req;
    logic        w_flush_close;
    logic        w_to_due;
    logic        w_to_close;
    logic        w_close;
    logic [1:0]  w_count_nxt;
    word_t       w_word;
    word_t       w_head;

    assign w_hs   = bus.s_valid_i & r_s_ready;
    assign w_pop  = (r_count != 2'd0) & bus.m_ready_i;
    // A slot is free if not full, or the head leaves this same cycle.
    assign w_space = (r_count != 2'd2) | w_pop;
    assign w_part  = (r_idx != '0);

    // An accepted beat always has room: s_ready was only raised with count<2.
    assign w_beat_close = w_hs & ((r_idx == IDXW'(T_DATA_RATIO - 1)) | bus.s_last_i);

    // Flush covers a beat arriving in the same cycle; with nothing held and
    // no beat it is a no-op.
    assign w_flush_req   = bus.flush_i | r_flush_pend;
    assign w_flush_close = w_flush_req & w_space & (w_hs | w_part);

    assign w_to_due   = (IDLE_TIMEOUT != 0) & w_part & ~w_hs & (r_tcnt == TW'(TMAX));
    assign w_to_close = w_to_due & w_space;

    assign w_close     = w_beat_close | w_flush_close | w_to_close;
    assign w_count_nxt = r_count + {1'b0, w_close} - {1'b0, w_pop};

    // Word as it would be pushed this cycle: held lanes plus the incoming beat.
    always_comb begin
        w_word.data = r_lane;
        w_word.keep = r_keep;
        w_word.last = w_hs & bus.s_last_i;
        if (w_hs) begin
            w_word.data[r_idx] = bus.s_data_i;
            w_word.keep[r_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane       <= '0;
            r_keep       <= '0;
            r_idx        <= '0;
            r_tcnt       <= '0;
            r_flush_pend <= 1'b0;
            r_buf[0]     <= '0;
            r_buf[1]     <= '0;
            r_rd_ptr     <= 1'b0;
            r_wr_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_s_ready    <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_s_ready <= (w_count_nxt != 2'd2);

            if (w_close) begin
                r_buf[r_wr_ptr] <= w_word;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;

            // Cleared lanes are what makes unfilled lanes read back as 0.
            if (w_close) begin
                r_lane <= '0;
                r_keep <= '0;
                r_idx  <= '0;
            end else if (w_hs) begin
                r_lane[r_idx] <= bus.s_data_i;
                r_keep[r_idx] <= 1'b1;
                r_idx         <= r_idx + 1'b1;
            end

            // Saturates at TMAX so a deferred timeout keeps requesting.
            if (w_hs || w_close || !w_part)
                r_tcnt <= '0;
            else if (r_tcnt != TW'(TMAX))
                r_tcnt <= r_tcnt + 1'b1;

            if (w_close)
                r_flush_pend <= 1'b0;
            else if (!w_hs && !w_part)
                r_flush_pend <= 1'b0;
            else
                r_flush_pend <= w_flush_req;
        end
    end

    assign w_head        = r_buf[r_rd_ptr];
    assign bus.s_ready_o = r_s_ready;
    assign bus.m_valid_o = (r_count != 2'd0);
    assign bus.m_keep_o  = w_head.keep;
    assign bus.m_last_o  = w_head.last;

    for (genvar g = 0; g < T_DATA_RATIO; g++) begin : g_lane
        assign bus.m_data_o[g] = w_head.data[g];
    end
endmodule

// File: tb/tb_stream_upsize_flush.sv
module tb_stream_upsize_flush;
    localparam int W = 4;
    localparam int R = 2;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_upsize_flush_if #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) bus();

    stream_upsize_flush #(
        .T_DATA_WIDTH(W), .T_DATA_RATIO(R), .IDLE_TIMEOUT(T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [R-1:0][W-1:0] data;
        logic [R-1:0]        keep;
        logic                last;
    } word_t;

    word_t exp_q[$];
    int    pd[$];     // beats of the packet word being gathered
    int    idle_n;
    int    n_vec = 0;
    int    n_err = 0;

    // ---------------- reference model (queue of beats -> words) -------------
    function automatic void close_word(input logic lst);
        word_t w;
        w.data = '0;
        w.keep = '0;
        for (int i = 0; i < pd.size(); i++) begin
            w.data[i] = W'(pd[i]);
            w.keep[i] = 1'b1;
        end
        w.last = lst;
        exp_q.push_back(w);
        pd.delete();
        idle_n = 0;
    endfunction

    function automatic void model(input logic acc, input logic [W-1:0] d,
                                  input logic l, input logic f);
        if (acc) begin
            pd.push_back(int'(d));
            idle_n = 0;
            if (pd.size() == R || l) close_word(l);
        end
        if (f && pd.size() > 0)
            close_word(1'b0);
        else if (!acc && pd.size() > 0) begin
            idle_n++;
            if (idle_n == T) close_word(1'b0);
        end
    endfunction

    function automatic void model_reset();
        pd.delete();
        exp_q.delete();
        idle_n = 0;
    endfunction

    // ---------------- checks ------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [R*W-1:0] out_data();
        logic [R-1:0][W-1:0] d;
        for (int i = 0; i < R; i++) d[i] = bus.m_data_o[i];
        return d;
    endfunction

    task automatic monitor();
        word_t e;
        logic [R-1:0][W-1:0] d;
        forever begin
            @(negedge clk);
            if (rst_n && bus.m_valid_o && bus.m_ready_i) begin
                d = out_data();
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL word: unexpected data=%h keep=%b last=%b",
                             d, bus.m_keep_o, bus.m_last_o);
                end else begin
                    e = exp_q.pop_front();
                    if (d !== e.data || bus.m_keep_o !== e.keep || bus.m_last_o !== e.last) begin
                        n_err++;
                        $display("FAIL word: got data=%h keep=%b last=%b, expected data=%h keep=%b last=%b",
                                 d, bus.m_keep_o, bus.m_last_o, e.data, e.keep, e.last);
                    end
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------------------------------------
    task automatic step(input logic v, input logic [W-1:0] d, input logic l,
                        input logic f, output logic acc);
        bus.s_valid_i = v;
        bus.s_data_i  = d;
        bus.s_last_i  = l;
        bus.flush_i   = f;
        acc = v & bus.s_ready_o;
        model(acc, d, l, f);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic l, input logic f);
        logic acc;
        for (int k = 0; k < 50; k++) begin
            step(1'b1, d, l, f, acc);
            if (acc) return;
        end
        chk("send timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) step(1'b0, '0, 1'b0, 1'b0, acc);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
        bus.s_last_i  = 1'b0;
        bus.flush_i   = 1'b0;
        model_reset();
        #1;
        chk("rst s_ready", 32'(bus.s_ready_o), 32'd0);
        chk("rst m_valid", 32'(bus.m_valid_o), 32'd0);
        chk("rst m_keep",  32'(bus.m_keep_o),  32'd0);
        chk("rst m_last",  32'(bus.m_last_o),  32'd0);
        chk("rst m_data",  32'(out_data()),    32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready after reset", 32'(bus.s_ready_o), 32'd1);
    endtask

    task automatic main_seq();
        logic acc;
        int   got;
        bus.m_ready_i = 1'b1;
        do_reset();

        // 1: two-beat packet, latency
        send(4'hA, 1'b0, 1'b0);
        chk("t1 no early valid", 32'(bus.m_valid_o), 32'd0);
        send(4'hB, 1'b1, 1'b0);
        chk("t1 latency", 32'(bus.m_valid_o), 32'd1);
        idle(2);

        // 2: odd-length packet
        send(4'h1, 1'b0, 1'b0);
        send(4'h2, 1'b0, 1'b0);
        send(4'h3, 1'b1, 1'b0);
        idle(3);

        // 3: output stall fills the buffer
        bus.m_ready_i = 1'b0;
        got = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, W'(got + 1), 1'b0, 1'b0, acc);
            if (acc) got++;
        end
        chk("t3 accepted", 32'(got), 32'd4);
        chk("t3 s_ready low", 32'(bus.s_ready_o), 32'd0);
        chk("t3 held valid", 32'(bus.m_valid_o), 32'd1);
        bus.m_ready_i = 1'b1;
        send(4'h5, 1'b0, 1'b0);
        send(4'h6, 1'b0, 1'b0);
        idle(4);

        // 4: idle timeout
        send(4'h5, 1'b0, 1'b0);
        idle(3);
        chk("t4 before timeout", 32'(bus.m_valid_o), 32'd0);
        idle(1);
        chk("t4 at timeout", 32'(bus.m_valid_o), 32'd1);
        idle(2);

        // 5: flush with beat, flush with nothing held
        send(4'h7, 1'b0, 1'b1);
        chk("t5 flush close", 32'(bus.m_valid_o), 32'd1);
        idle(2);
        step(1'b0, '0, 1'b0, 1'b1, acc);
        idle(2);
        chk("t5 empty flush", 32'(bus.m_valid_o), 32'd0);
        send(4'h3, 1'b0, 1'b0);
        idle(2);
        chk("t5 no stale flush", 32'(bus.m_valid_o), 32'd0);
        idle(4);

        // 6: reset mid-packet
        send(4'h4, 1'b0, 1'b0);
        do_reset();
        send(4'h8, 1'b0, 1'b0);
        send(4'h9, 1'b1, 1'b0);
        chk("t6 after reset", 32'(bus.m_valid_o), 32'd1);
        idle(2);

        // random traffic with stalls, flushes and idle gaps
        for (int c = 0; c < 3000; c++) begin
            bus.m_ready_i = ($urandom_range(0, 99) < 60);
            step($urandom_range(0, 99) < 70, W'($urandom), $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 5, acc);
        end
        bus.m_ready_i = 1'b1;
        idle(12);
        chk("queue drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
        bus.s_last_i  = 1'b0;
        bus.flush_i   = 1'b0;
        bus.m_ready_i = 1'b0;
        idle_n = 0;
        fork
            monitor();
            main_seq();
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
